// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: buffers ALU and load results in a small FIFO and
// drives the register file write port, one write per cycle, with forwarding
// lookups over all pending writes.
// Optional macro WB_BYPASS_EN: when the queue is empty and the register file
// is free, an accepted result goes straight to the write port registers.
module regfile_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     CLOCK_50,
  input  logic                     Rest,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_addr,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     mem_ready,
  input  logic                     rf_busy,
  output logic                     write_sig,
  output logic [ADDR_W-1:0]        d_addr,
  output logic [DATA_W-1:0]        writeback_data,
  input  logic [ADDR_W-1:0]        a_addr,
  input  logic [ADDR_W-1:0]        b_addr,
  output logic                     a_fwd_hit,
  output logic [DATA_W-1:0]        a_fwd_data,
  output logic                     b_fwd_hit,
  output logic [DATA_W-1:0]        b_fwd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  logic              full;
  logic              empty;
  logic              take_mem;
  logic              take_alu;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              live;
  logic              bypass;
  logic              push;
  logic              pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;

  // Select the accepted offer (loads win) and decide push/pop/bypass.
  always_comb begin
    take_mem = mem_valid && mem_ready;
    take_alu = alu_valid && alu_ready;
    in_addr  = take_mem ? mem_addr : alu_addr;
    in_data  = take_mem ? mem_data : alu_data;
    live     = (take_mem || take_alu) && (in_addr != '0);
    pop      = !empty && !rf_busy;
`ifdef WB_BYPASS_EN
    bypass   = live && empty && !rf_busy;
`else
    bypass   = 1'b0;
`endif
    push     = live && !bypass;
  end

  // Entry storage; contents are only meaningful between head and tail.
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      q_addr[tail] <= in_addr;
      q_data[tail] <= in_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge CLOCK_50) begin
    if (Rest) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Register file write port: pop the head, or take a bypassed offer.
  always_ff @(posedge CLOCK_50) begin
    if (Rest) begin
      write_sig      <= 1'b0;
      d_addr         <= '0;
      writeback_data <= '0;
    end else if (pop) begin
      write_sig      <= 1'b1;
      d_addr         <= q_addr[head];
      writeback_data <= q_data[head];
    end else if (bypass) begin
      write_sig      <= 1'b1;
      d_addr         <= in_addr;
      writeback_data <= in_data;
    end else begin
      write_sig      <= 1'b0;
    end
  end

  // Scan oldest to youngest so the last match (youngest) is what remains.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] key);
    logic [DATA_W:0]  res;
    logic [PTR_W-1:0] idx;
    res = '0;
    idx = '0;
    if (write_sig && d_addr == key) res = {1'b1, writeback_data};
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (CNT_W'(i) < count && q_addr[idx] == key) res = {1'b1, q_data[idx]};
    end
    if (key == '0) res = '0;
    return res;
  endfunction

  // Forwarding lookups for both read ports.
  always_comb begin
    {a_fwd_hit, a_fwd_data} = lookup(a_addr);
    {b_fwd_hit, b_fwd_data} = lookup(b_addr);
  end

endmodule
